// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between an IF read port and a DM load/store port
//  in : clk, rst (async, active-high), if_req/if_addr, dm_req/dm_we/dm_addr/dm_wdata/dm_be, mem_rdata
//  out: if_rdata/if_ready, dm_rdata/dm_ready, mem_en/mem_we/mem_addr/mem_wdata/mem_be, busy
//  DM wins arbitration unless IF has been passed over STARVE_MAX times in a row; each access holds
//  the memory for MEM_LAT cycles, then the owner gets a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_be,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);
  localparam int BW = DATA_W / 8;
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              take, pick_dm, in_busy, last, starved;
  always_comb begin
    in_busy    = state_q == BUSY;
    last       = in_busy && cnt_q == '0;
    take       = state_q == IDLE && (if_req || dm_req);
    starved    = if_req && starve_q == SW'(STARVE_MAX);
    pick_dm    = dm_req && !starved;
    state_d    = take ? BUSY : in_busy ? (last ? RESP : BUSY) : IDLE;
    cnt_d      = take ? CW'(MEM_LAT - 1) : (in_busy && !last) ? cnt_q - 1'b1 : cnt_q;
    owner_d    = take ? pick_dm : owner_q;
    we_d       = take ? pick_dm && dm_we : we_q;
    addr_d     = take ? (pick_dm ? dm_addr : if_addr) : addr_q;
    wdata_d    = take ? (pick_dm ? dm_wdata : '0) : wdata_q;
    be_d       = take ? (pick_dm ? dm_be : '0) : be_q;
    // Passing over a waiting IF counts toward starvation; anything else clears it.
    starve_d   = !take ? starve_q : (pick_dm && if_req) ? (starved ? starve_q : starve_q + 1'b1) : '0;
    if_rdata_d = (last && !owner_q) ? mem_rdata : if_rdata_q;
    dm_rdata_d = (last && owner_q && !we_q) ? mem_rdata : dm_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  // Enables decode straight from state so an async reset drops them immediately.
  assign mem_en    = state_q == BUSY;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign if_ready  = state_q == RESP && !owner_q;
  assign dm_ready  = state_q == RESP && owner_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 second instance)
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        dm;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        if_req, if_ready, dm_req, dm_we, dm_ready, mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        b_if_req, b_if_ready, b_dm_req, b_dm_we, b_dm_ready, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_dm_be, b_mem_be;
  logic [31:0] model [0:4095];
  exp_t        sbq[$];
  int          applied = 0;
  int          miscompares = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .dm_be(b_dm_be),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );
  assign mem_rdata   = model[mem_addr[13:2]];
  assign b_mem_rdata = b_mem_addr ^ 32'hA5A5A5A5;
  always @(posedge clk)
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) model[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic expect_rsp(input logic dm, input logic [31:0] data);
    sbq.push_back('{dm: dm, data: data});
  endtask
  task automatic wait_ready(input logic dm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dm ? dm_ready : if_ready) && n < 50);
    if (!(dm ? dm_ready : if_ready)) check(dm ? "dm_ready_timeout" : "if_ready_timeout", 32'd0, 32'd1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (if_ready && dm_ready) check("both_ready", 32'd1, 32'd0);
    else if (if_ready || dm_ready) begin
      if (sbq.size() == 0) check("unexpected_ready", {31'd0, dm_ready}, 32'hFFFFFFFF);
      else begin
        e = sbq.pop_front();
        check("ready_port", {31'd0, dm_ready}, {31'd0, e.dm});
        check(dm_ready ? "dm_rdata" : "if_rdata", dm_ready ? dm_rdata : if_rdata, e.data);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, nd, ni, k, ipos;
    logic [9:0] order;
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    model[32'h100 >> 2]  = 32'h00A00093;
    model[32'h104 >> 2]  = 32'h00B00113;
    model[32'h2000 >> 2] = 32'hCAFEF00D;
    model[32'h40 >> 2]   = 32'h11223344;
    rst = 1'b1;
    {if_req, dm_req, dm_we} = '0;
    {if_addr, dm_addr, dm_wdata} = '0;
    dm_be = '0;
    {b_if_req, b_dm_req, b_dm_we} = '0;
    {b_if_addr, b_dm_addr, b_dm_wdata} = '0;
    b_dm_be = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // IF-only read: BUSY cycles 1-2, ready cycle 3
    if_addr = 32'h100;
    if_req  = 1'b1;
    expect_rsp(1'b0, 32'h00A00093);
    @(negedge clk);
    check("t1_mem_en_c1", {31'd0, mem_en}, 32'd1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("t1_mem_en_c2", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    check("t1_if_ready_c3", {31'd0, if_ready}, 32'd1);
    check("t1_dm_ready_c3", {31'd0, dm_ready}, 32'd0);
    check("t1_mem_en_resp", {31'd0, mem_en}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_idle", {31'd0, busy}, 32'd0);
    // Simultaneous requests: DM first (ready cycle 3), IDLE in cycle 4, IF BUSY 5-6, ready 7
    dm_addr = 32'h2000; dm_we = 1'b0; dm_req = 1'b1;
    if_addr = 32'h104;  if_req = 1'b1;
    expect_rsp(1'b1, 32'hCAFEF00D);
    expect_rsp(1'b0, 32'h00B00113);
    nd = 0; ni = 0; n = 0;
    while (ni == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (dm_ready) begin nd = n; dm_req = 1'b0; end
      if (if_ready) begin ni = n; if_req = 1'b0; end
    end
    check("t2_dm_ready_cycle", nd, 32'd3);
    check("t2_if_ready_cycle", ni, 32'd7);
    @(negedge clk);
    // Starvation: both held; IF gets every fifth grant and starvation restarts after it
    dm_addr = 32'h2000; dm_req = 1'b1;
    if_addr = 32'h100;  if_req = 1'b1;
    for (int i = 0; i < 10; i++) expect_rsp(i % 5 != 4, (i % 5 != 4) ? 32'hCAFEF00D : 32'h00A00093);
    k = 0; n = 0; ipos = 0; order = '0;
    while (k < 10 && n < 100) begin
      @(negedge clk);
      n++;
      if (if_ready || dm_ready) begin
        order[k] = dm_ready;
        if (if_ready && ipos == 0) ipos = k + 1;
        k++;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    check("t3_grant_count", k, 32'd10);
    check("t3_grant_order", {22'd0, order}, {22'd0, 10'b0111101111});
    check("t3_first_if_pos", ipos, 32'd5);
    @(negedge clk);
    // Store: dm_rdata keeps last load value; memory gets only low two bytes
    dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011; dm_we = 1'b1; dm_req = 1'b1;
    expect_rsp(1'b1, 32'hCAFEF00D);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("t4_mem_we", {31'd0, mem_we}, 32'd1);
      check("t4_mem_addr", mem_addr, 32'h40);
      check("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("t4_mem_be", {28'd0, mem_be}, 32'd3);
    end
    @(negedge clk);
    check("t4_dm_ready", {31'd0, dm_ready}, 32'd1);
    check("t4_mem_we_resp", {31'd0, mem_we}, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    dm_req = 1'b1;
    expect_rsp(1'b1, 32'h1122BEEF);
    wait_ready(1'b1, n);
    dm_req = 1'b0;
    @(negedge clk);
    // Reset in first BUSY cycle aborts; after release a fresh read takes MEM_LAT+1 cycles
    if_addr = 32'h104; if_req = 1'b1;
    @(negedge clk);
    check("t5_mem_en_before", {31'd0, mem_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_mem_en_async", {31'd0, mem_en}, 32'd0);
    check("t5_busy_async", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_rsp(1'b0, 32'h00B00113);
    wait_ready(1'b0, n);
    check("t5_latency", n, 32'd3);
    if_req = 1'b0;
    @(negedge clk);
    // MEM_LAT=1 instance: request dropped in BUSY still completes; new grant waits for IDLE
    b_dm_addr = 32'h2000; b_dm_req = 1'b1;
    @(negedge clk);
    check("t6_mem_en", {31'd0, b_mem_en}, 32'd1);
    check("t6_mem_addr", b_mem_addr, 32'h2000);
    b_dm_req = 1'b0;
    @(negedge clk);
    check("t6_dm_ready", {31'd0, b_dm_ready}, 32'd1);
    check("t6_dm_rdata", b_dm_rdata, 32'hA5A585A5);
    b_if_addr = 32'h300; b_if_req = 1'b1;
    @(negedge clk);
    check("t6_no_grant_from_resp", {31'd0, b_busy}, 32'd0);
    @(negedge clk);
    check("t6_if_mem_en", {31'd0, b_mem_en}, 32'd1);
    check("t6_if_mem_addr", b_mem_addr, 32'h300);
    @(negedge clk);
    check("t6_if_ready", {31'd0, b_if_ready}, 32'd1);
    check("t6_if_rdata", b_if_rdata, 32'hA5A5A6A5);
    check("t6_dm_ready_quiet", {31'd0, b_dm_ready}, 32'd0);
    b_if_req = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
